// File: rtl/sha256_serial_pkg.sv
// Shared definitions for the SHA-256 serial host: FSM state encoding and
// default geometry of the message/digest transfer.
package sha256_serial_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_WAIT,
    LOAD_SHIFT,
    START,
    WAIT_DONE,
    READ_SHIFT,
    READ_HOLD
  } state_t;

  localparam int unsigned DEF_MSG_BYTES  = 64;
  localparam int unsigned DEF_HASH_BYTES = 32;
  localparam int unsigned DEF_TIMEOUT    = 4096;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sha256_bit_shifter.sv
// 8-bit shift register with parallel load, MSB-first serial out and LSB serial in;
// serialises message bytes and deserialises digest bytes.
module sha256_bit_shifter (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] load_data,
  input  logic       shift,
  input  logic       ser_in,
  output logic       ser_out,
  output logic [7:0] data
);

  logic [7:0] sreg;

  always_ff @(posedge clk) begin
    if (reset) begin
      sreg <= '0;
    end else if (load) begin
      sreg <= load_data;
    end else if (shift) begin
      sreg <= {sreg[6:0], ser_in};
    end
  end

  assign ser_out = sreg[7];
  assign data    = sreg;

endmodule

// File: rtl/sha256_serial_host.sv
// Byte-stream host for a bit-serial SHA-256 core: shifts one message block in,
// starts the core, waits for completion (with timeout) and streams the digest out.
module sha256_serial_host
  import sha256_serial_pkg::*;
#(
  parameter int unsigned MSG_BYTES  = DEF_MSG_BYTES,
  parameter int unsigned HASH_BYTES = DEF_HASH_BYTES,
  parameter int unsigned TIMEOUT    = DEF_TIMEOUT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       ser_mosi,
  output logic       ser_shift,
  output logic       ser_start,
  input  logic       ser_done,
  input  logic       ser_miso,
  output logic       busy,
  output logic       err
);

  localparam int unsigned MAX_BYTES = max_u(MSG_BYTES, HASH_BYTES);
  localparam int unsigned BYTE_W    = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;
  localparam int unsigned TO_W      = $clog2(TIMEOUT + 1);

  localparam logic [BYTE_W-1:0] MSG_LAST  = BYTE_W'(MSG_BYTES - 1);
  localparam logic [BYTE_W-1:0] HASH_LAST = BYTE_W'(HASH_BYTES - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [BYTE_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic              err_q, err_d;

  logic       ready_en, shift_en, start_en, hold_en, sh_load;
  logic       sh_out;
  logic [7:0] sh_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      to_cnt_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      to_cnt_q   <= to_cnt_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    to_cnt_d   = to_cnt_q;
    err_d      = err_q;
    ready_en   = 1'b0;
    shift_en   = 1'b0;
    start_en   = 1'b0;
    hold_en    = 1'b0;
    sh_load    = 1'b0;
    unique case (state_q)
      IDLE, LOAD_WAIT: begin
        ready_en = 1'b1;
        if (in_valid) begin
          sh_load   = 1'b1;
          bit_cnt_d = '0;
          state_d   = LOAD_SHIFT;
        end
      end
      LOAD_SHIFT: begin
        shift_en  = 1'b1;
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          if (byte_cnt_q == MSG_LAST) begin
            byte_cnt_d = '0;
            state_d    = START;
          end else begin
            byte_cnt_d = byte_cnt_q + BYTE_W'(1);
            state_d    = LOAD_WAIT;
          end
        end
      end
      START: begin
        start_en = 1'b1;
        to_cnt_d = '0;
        state_d  = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (ser_done) begin
          bit_cnt_d = '0;
          state_d   = READ_SHIFT;
        end else if (to_cnt_q == TO_LAST) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      READ_SHIFT: begin
        shift_en  = 1'b1;
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          state_d = READ_HOLD;
        end
      end
      READ_HOLD: begin
        hold_en = 1'b1;
        if (out_ready) begin
          if (byte_cnt_q == HASH_LAST) begin
            byte_cnt_d = '0;
            state_d    = IDLE;
          end else begin
            byte_cnt_d = byte_cnt_q + BYTE_W'(1);
            bit_cnt_d  = '0;
            state_d    = READ_SHIFT;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  sha256_bit_shifter u_shifter (
    .clk       (clk),
    .reset     (reset),
    .load      (sh_load),
    .load_data (in_data),
    .shift     (shift_en),
    .ser_in    (ser_miso & (state_q == READ_SHIFT)),
    .ser_out   (sh_out),
    .data      (sh_data)
  );

  // Outputs are forced low combinationally so reset silences the core link
  // in the same cycle it is raised, not one edge later.
  assign in_ready  = ready_en & ~reset;
  assign ser_shift = shift_en & ~reset;
  assign ser_start = start_en & ~reset;
  assign out_valid = hold_en & ~reset;
  assign out_data  = out_valid ? sh_data : '0;
  assign ser_mosi  = ser_shift & sh_out;
  assign busy      = (state_q != IDLE) & ~reset;
  assign err       = err_q & ~reset;

endmodule

// File: tb/tb_sha256_serial_host.sv
// Directed bench for sha256_serial_host with a bit-serial core model and
// queue-based scoreboards for message bits and digest bytes.
module tb_sha256_serial_host;

  localparam int unsigned TO       = 200;
  localparam int unsigned CORE_LAT = 20;
  localparam logic [511:0] ABC_BLK = {32'h61626380, 472'h0, 8'h18};
  localparam logic [255:0] ABC_DIG =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;

  logic       clk;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       ser_mosi;
  logic       ser_shift;
  logic       ser_start;
  logic       ser_done;
  logic       ser_miso;
  logic       busy;
  logic       err;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic        exp_bits[$];
  logic [7:0]  exp_dig[$];
  int unsigned xfers, shifts, starts, rx_n;
  logic [7:0]  rx [32];

  logic         core_hang, core_flush;
  logic [1:0]   cphase;
  logic [511:0] cmsg;
  logic [255:0] cdig;
  int unsigned  cdelay, cbits;

  sha256_serial_host #(
    .MSG_BYTES  (64),
    .HASH_BYTES (32),
    .TIMEOUT    (TO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ser_mosi  (ser_mosi),
    .ser_shift (ser_shift),
    .ser_start (ser_start),
    .ser_done  (ser_done),
    .ser_miso  (ser_miso),
    .busy      (busy),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Core model: 512-bit capture, digest chosen by whether the block was received intact.
  assign ser_miso = cdig[255];
  always @(posedge clk) begin
    if (core_flush) begin
      cphase   <= 2'd0;
      ser_done <= 1'b0;
      cmsg     <= '0;
      cdig     <= '0;
      cbits    <= 0;
      cdelay   <= 0;
    end else begin
      case (cphase)
        2'd0: begin
          if (ser_shift) cmsg <= {cmsg[510:0], ser_mosi};
          if (ser_start) begin
            cdig   <= (cmsg == ABC_BLK) ? ABC_DIG : ~ABC_DIG;
            cdelay <= CORE_LAT;
            cphase <= 2'd1;
          end
        end
        2'd1: begin
          if (!core_hang) begin
            if (cdelay == 0) begin
              ser_done <= 1'b1;
              cbits    <= 0;
              cphase   <= 2'd2;
            end else begin
              cdelay <= cdelay - 1;
            end
          end
        end
        default: begin
          if (ser_shift) begin
            cdig  <= {cdig[254:0], 1'b0};
            cbits <= cbits + 1;
            if (cbits == 255) begin
              ser_done <= 1'b0;
              cphase   <= 2'd0;
            end
          end
        end
      endcase
    end
  end

  function automatic logic [7:0] abc_byte(input int unsigned i);
    logic [511:0] blk;
    blk = ABC_BLK;
    return blk[511 - 8*i -: 8];
  endfunction

  function automatic logic [7:0] dig_byte(input int unsigned i);
    logic [255:0] d;
    d = ABC_DIG;
    return d[255 - 8*i -: 8];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Entered and left at posedge+1.
  task automatic send_byte(input logic [7:0] b, input bit rnd);
    bit          done;
    int unsigned n;
    done = 1'b0;
    n    = 0;
    while (!done && n < 200) begin
      if (in_ready) begin
        in_data  = b;
        in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      end else begin
        in_data  = 8'($urandom);
        in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      done = in_valid && in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    in_data  = '0;
    chk("send_byte_accepted", 32'(done), 1);
  endtask

  task automatic send_block(input bit rnd);
    for (int unsigned i = 0; i < 64; i++) send_byte(abc_byte(i), rnd);
  endtask

  task automatic do_reset(input int unsigned n);
    reset    = 1'b1;
    in_valid = 1'b0;
    repeat (n) begin
      @(negedge clk);
      chk("rst_in_ready", 32'(in_ready), 0);
      chk("rst_ser_shift", 32'(ser_shift), 0);
      chk("rst_ser_mosi", 32'(ser_mosi), 0);
      chk("rst_ser_start", 32'(ser_start), 0);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_out_data", 32'(out_data), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_err", 32'(err), 0);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(in_ready), 1);
    chk("post_rst_busy", 32'(busy), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    int unsigned n;
    n = 0;
    @(negedge clk);
    while (busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(busy), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0]  pat;
    int unsigned n, s0;

    reset      = 1'b1;
    in_data    = '0;
    in_valid   = 1'b0;
    out_ready  = 1'b1;
    core_hang  = 1'b0;
    core_flush = 1'b1;
    rx_n       = 0;
    xfers      = 0;
    shifts     = 0;
    starts     = 0;

    fork
      begin
        @(posedge clk);
        forever begin
          @(negedge clk);
          if (!ser_shift) chk("mosi_low_when_idle", 32'(ser_mosi), 0);
          if (reset) begin
            exp_bits.delete();
            exp_dig.delete();
            xfers  = 0;
            shifts = 0;
          end else begin
            if (in_valid && in_ready) begin
              xfers++;
              for (int k = 7; k >= 0; k--) exp_bits.push_back(in_data[k]);
            end
            if (ser_shift && cphase != 2'd2) begin
              shifts++;
              if (exp_bits.size() == 0) chk("mosi_unexpected_shift", 32'(ser_shift), 0);
              else chk("mosi_bit", 32'(ser_mosi), 32'(exp_bits.pop_front()));
            end
            if (ser_start) begin
              chk("xfers_before_start", xfers, 64);
              chk("shifts_before_start", shifts, 512);
              xfers  = 0;
              shifts = 0;
              starts++;
              if (!core_hang) for (int unsigned i = 0; i < 32; i++) exp_dig.push_back(dig_byte(i));
            end
            if (out_valid && out_ready) begin
              if (exp_dig.size() == 0) chk("out_unexpected", 32'(out_valid), 0);
              else chk("digest_byte", 32'(out_data), 32'(exp_dig.pop_front()));
              if (rx_n < 32) rx[rx_n] = out_data;
              rx_n++;
            end
          end
        end
      end
    join_none

    repeat (2) @(posedge clk);
    #1;
    core_flush = 1'b0;
    do_reset(2);

    // Single byte 0xA5 straight after reset.
    pat = 8'hA5;
    send_byte(pat, 1'b0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("a5_shift", 32'(ser_shift), 1);
      chk("a5_mosi", 32'(ser_mosi), 32'(pat[7-k]));
    end
    @(negedge clk);
    chk("a5_in_ready_again", 32'(in_ready), 1);
    chk("a5_busy", 32'(busy), 1);
    @(posedge clk);
    #1;
    do_reset(1);

    // "abc" block with the sink stalled on digest byte 0.
    out_ready = 1'b0;
    rx_n      = 0;
    s0        = starts;
    send_block(1'b0);
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 1000) begin
      @(negedge clk);
      n++;
    end
    for (int k = 0; k < 20; k++) begin
      chk("stall_out_valid", 32'(out_valid), 1);
      chk("stall_out_data", 32'(out_data), 32'h0000_00ba);
      chk("stall_ser_shift", 32'(ser_shift), 0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_idle("abc_done");
    chk("abc_one_start", starts - s0, 1);
    chk("abc_rx_count", rx_n, 32);
    chk("abc_byte0", 32'(rx[0]), 32'h0000_00ba);
    chk("abc_byte1", 32'(rx[1]), 32'h0000_0078);
    chk("abc_byte2", 32'(rx[2]), 32'h0000_0016);
    chk("abc_byte3", 32'(rx[3]), 32'h0000_00bf);
    chk("abc_byte30", 32'(rx[30]), 32'h0000_0015);
    chk("abc_byte31", 32'(rx[31]), 32'h0000_00ad);
    chk("abc_sb_empty", exp_dig.size(), 0);

    // Random in_valid during load.
    rx_n = 0;
    s0   = starts;
    send_block(1'b1);
    wait_idle("rnd_done");
    chk("rnd_one_start", starts - s0, 1);
    chk("rnd_rx_count", rx_n, 32);

    // Reset while message byte 30 is being shifted, then a full block.
    for (int unsigned i = 0; i < 30; i++) send_byte(abc_byte(i), 1'b0);
    send_byte(abc_byte(30), 1'b0);
    @(negedge clk);
    chk("b30_shifting", 32'(ser_shift), 1);
    @(posedge clk);
    #1;
    do_reset(2);
    rx_n = 0;
    s0   = starts;
    send_block(1'b0);
    wait_idle("resync_done");
    chk("resync_one_start", starts - s0, 1);
    chk("resync_rx_count", rx_n, 32);
    chk("resync_byte31", 32'(rx[31]), 32'h0000_00ad);

    // Core never finishes: timeout.
    core_hang = 1'b1;
    rx_n      = 0;
    send_block(1'b0);
    n = 0;
    @(negedge clk);
    while (!ser_start && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("to_start_seen", 32'(ser_start), 1);
    @(posedge clk);
    repeat (TO - 1) @(posedge clk);
    @(negedge clk);
    chk("to_err_early", 32'(err), 0);
    chk("to_busy_early", 32'(busy), 1);
    @(posedge clk);
    @(negedge clk);
    chk("to_err_set", 32'(err), 1);
    @(negedge clk);
    chk("to_busy_after", 32'(busy), 0);
    chk("to_err_sticky", 32'(err), 1);
    chk("to_no_output", rx_n, 0);
    @(posedge clk);
    #1;
    core_flush = 1'b1;
    core_hang  = 1'b0;
    @(posedge clk);
    #1;
    core_flush = 1'b0;

    // New block still runs with err set; only reset clears err.
    send_block(1'b0);
    wait_idle("err_block_done");
    chk("err_block_rx_count", rx_n, 32);
    chk("err_still_set", 32'(err), 1);
    do_reset(1);
    chk("err_cleared", 32'(err), 0);
    chk("final_sb_empty", exp_dig.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
